// File: rtl/iter_alu_if.sv
// Start/busy/done handshake bundle between the control FSM (master) and iter_alu (slave).
interface iter_alu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             busy;
  logic             done;
  logic             zero;
  logic             negative;
  logic             overflow;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  result, result_hi, busy, done, zero, negative, overflow, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output result, result_hi, busy, done, zero, negative, overflow, div_by_zero
  );
endinterface

// File: rtl/iter_alu.sv
// Registered ALU: single-cycle logic/arith ops plus radix-2 iterative signed MUL/DIV
// working on operand magnitudes, with the sign applied in a final FIX cycle.
module iter_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  iter_alu_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             sb_q, sb_d;
  logic [WIDTH-1:0] mb_q, mb_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             zero_q, zero_d;
  logic             negative_q, negative_d;
  logic             overflow_q, overflow_d;
  logic             dbz_q, dbz_d;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  // Single-cycle datapath, evaluated straight from the request inputs
  logic [WIDTH-1:0] sum_add, sum_sub, sum_rsub;
  logic [WIDTH-1:0] sc_result;
  logic             sc_ov;
  logic             a_msb, b_msb;

  assign sum_add  = bus.a + bus.b;
  assign sum_sub  = bus.a - bus.b;
  assign sum_rsub = bus.b - bus.a;
  assign a_msb    = bus.a[WIDTH-1];
  assign b_msb    = bus.b[WIDTH-1];

  always_comb begin
    sc_result = '0;
    sc_ov     = 1'b0;
    case (bus.op)
      3'b000: sc_result = bus.a & bus.b;
      3'b001: begin
        sc_result = sum_add;
        sc_ov     = (a_msb == b_msb) && (sum_add[WIDTH-1] != a_msb);
      end
      3'b010: begin
        sc_result = sum_sub;
        sc_ov     = (a_msb != b_msb) && (sum_sub[WIDTH-1] != a_msb);
      end
      3'b011: begin
        sc_result = sum_rsub;
        sc_ov     = (a_msb != b_msb) && (sum_rsub[WIDTH-1] != b_msb);
      end
      3'b100: sc_result = bus.a | bus.b;
      3'b101: sc_result = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      default: sc_result = '0;
    endcase
  end

  // One iteration step for each algorithm
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;

  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mb_q} : '0);
  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, mb_q};
  assign div_sub   = div_shift[WIDTH-1:0] - mb_q;

  // Sign correction applied in FIX
  logic                 res_neg;
  logic [2*WIDTH-1:0]   prod_mag, prod;
  logic [WIDTH-1:0]     quot, rem;

  assign res_neg  = a_q[WIDTH-1] ^ sb_q;
  assign prod_mag = {hi_q, lo_q};
  assign prod     = res_neg ? -prod_mag : prod_mag;
  assign quot     = res_neg ? -lo_q : lo_q;
  assign rem      = a_q[WIDTH-1] ? -hi_q : hi_q;

  logic             wb_en;
  logic [WIDTH-1:0] wb_result, wb_hi;
  logic             wb_ov, wb_dz;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_div_d    = is_div_q;
    a_d         = a_q;
    sb_d        = sb_q;
    mb_d        = mb_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    zero_d      = zero_q;
    negative_d  = negative_q;
    overflow_d  = overflow_q;
    dbz_d       = dbz_q;
    wb_en       = 1'b0;
    wb_result   = '0;
    wb_hi       = '0;
    wb_ov       = 1'b0;
    wb_dz       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.op[2:1] == 2'b11) begin
            state_d  = S_RUN;
            busy_d   = 1'b1;
            cnt_d    = '0;
            is_div_d = bus.op[0];
            a_d      = bus.a;
            sb_d     = b_msb;
            hi_d     = '0;
            if (bus.op[0]) begin
              mb_d = mag(bus.b);
              lo_d = mag(bus.a);
            end else begin
              mb_d = mag(bus.a);
              lo_d = mag(bus.b);
            end
          end else begin
            wb_en     = 1'b1;
            wb_result = sc_result;
            wb_ov     = sc_ov;
          end
        end
      end

      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (is_div_q) begin
          hi_d = div_ge ? div_sub : div_shift[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], div_ge};
        end else begin
          hi_d = mul_sum[WIDTH:1];
          lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIX;
      end

      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        wb_en   = 1'b1;
        if (is_div_q) begin
          if (mb_q == '0) begin
            wb_result = '1;
            wb_hi     = a_q;
            wb_dz     = 1'b1;
          end else begin
            wb_result = quot;
            wb_hi     = rem;
            // Quotient magnitude reaches 2^(WIDTH-1) only for MIN/+-1; positive sign overflows
            wb_ov     = lo_q[WIDTH-1] && !res_neg;
          end
        end else begin
          wb_result = prod[WIDTH-1:0];
          wb_hi     = prod[2*WIDTH-1:WIDTH];
          wb_ov     = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (wb_en) begin
      result_d    = wb_result;
      result_hi_d = wb_hi;
      zero_d      = (wb_result == '0);
      negative_d  = wb_result[WIDTH-1];
      overflow_d  = wb_ov;
      dbz_d       = wb_dz;
      done_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      a_q         <= '0;
      sb_q        <= 1'b0;
      mb_q        <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
      overflow_q  <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_div_q    <= is_div_d;
      a_q         <= a_d;
      sb_q        <= sb_d;
      mb_q        <= mb_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      zero_q      <= zero_d;
      negative_q  <= negative_d;
      overflow_q  <= overflow_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.result      = result_q;
  assign bus.result_hi   = result_hi_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.zero        = zero_q;
  assign bus.negative    = negative_q;
  assign bus.overflow    = overflow_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Parametrised, registered successor of the datapath ALU for the multicycle MIPS core.
- Single-cycle ops: AND, OR, ADD, SUB, RSUB, SLT. These complete one cycle after start.
- Iterative signed MUL and DIV: radix-2, one bit per cycle.
- Result, flags and a done pulse are driven to the control FSM through a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand/result width (≥4).
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk, input, 1, rising-edge clock.
- reset_n, input, 1, asynchronous active-low reset.
- start, input, 1, request. Sampled only when busy=0.
- op, input, 3: 000 AND, 001 ADD, 010 SUB (a-b), 011 RSUB (b-a), 100 OR, 101 SLT, 110 MUL, 111 DIV.
- a, input, WIDTH, signed operand A.
- b, input, WIDTH, signed operand B.
- result, output, WIDTH: registered result. For MUL, the low product. For DIV, the quotient.
- result_hi, output, WIDTH: MUL high product, DIV remainder, else 0.
- busy, output, 1, iterative op in progress.
- done, output, 1, one-cycle pulse when result/flags are updated.
- zero, output, 1, result==0 (low word only).
- negative, output, 1, result[WIDTH-1].
- overflow, output, 1, signed overflow (see below).
- div_by_zero, output, 1, DIV with b==0.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - All outputs are 0; state is IDLE; counter and internal registers are 0.
  - Reset mid-operation aborts immediately. No done pulse is issued.
- States:
  - IDLE: accepts start.
  - RUN: WIDTH iterations.
  - FIX: sign correction and writeback.
  - Transitions: IDLE→RUN on start with op[2:1]==11. RUN→FIX when counter==WIDTH-1. FIX→IDLE unconditionally.
- Operand capture: a, b and op are latched at the accepting edge. Later changes on the inputs have no effect.
- Single-cycle ops:
  - Start sampled at edge k: result and flags are registered at edge k, done=1 for the following cycle, busy stays 0.
  - Back-to-back starts every cycle are legal.
- Iterative ops:
  - busy=1 from edge k.
  - Iteration edges are k+1 … k+WIDTH.
  - Writeback happens at edge k+WIDTH+1. At that edge busy→0 and done=1 for one cycle.
  - Total latency is WIDTH+1 cycles.
  - start while busy=1 is ignored, not queued.
- MUL:
  - Operates on magnitudes with unsigned shift-add into a 2·WIDTH accumulator. Sign is applied in FIX (negate if a[MSB]^b[MSB]).
  - {result_hi,result} is the full signed product.
  - overflow=1 when result_hi is not the sign extension of result.
- DIV:
  - Operates on magnitudes with restoring shift-subtract.
  - Quotient is negated if signs differ. Remainder takes the sign of a (truncating division).
  - b==0: result = all ones, result_hi = a, div_by_zero=1, overflow=0. It still takes the full latency.
  - a = most-negative, b = -1: result = most-negative, result_hi = 0, overflow=1.
- ADD/SUB/RSUB:
  - Results wrap modulo 2^WIDTH.
  - overflow = signed overflow. ADD: operand signs equal and result sign differs. SUB/RSUB: the same rule applied to minuend vs negated subtrahend.
- AND/OR/SLT:
  - overflow=0.
  - SLT: result = 1 if signed a<b, else 0.
- result_hi:
  - 0 for all non-iterative ops.
  - div_by_zero: 0 except on DIV with b==0.
- Flags and result hold their values between done pulses. They change only at writeback edges.
- done and start in the same cycle (IDLE): the new op is accepted normally.

Test Plan (WIDTH=32):
- Reset then ADD:
  - 0x7FFFFFFF+1 → result 0x80000000, overflow=1, negative=1, done one cycle after start.
  - 5+(-5) → zero=1, overflow=0.
- SUB and RSUB:
  - SUB a=3, b=10 → 0xFFFFFFF9, negative=1.
  - RSUB same operands → 7.
  - SUB 0x80000000-1 → overflow=1.
- MUL:
  - -7×6 → result 0xFFFFFFD6, result_hi 0xFFFFFFFF, overflow=0.
  - busy for exactly 33 cycles, done at cycle 33.
  - 0x10000×0x10000 → result 0, result_hi 1, overflow=1, zero=1.
- DIV:
  - -17/5 → result 0xFFFFFFFD, result_hi 0xFFFFFFFE.
  - 0x80000000/-1 → overflow=1.
  - 9/0 → result 0xFFFFFFFF, result_hi 9, div_by_zero=1.
- Handshake:
  - Change a and b and pulse start mid-MUL → ignored, original product returned.
  - reset_n low at iteration 10 → all outputs 0, no done pulse.
  - A fresh start after release completes correctly.
- Back-to-back: AND, OR, SLT(-1,1) on consecutive cycles → three done pulses, results as expected and SLT result 1.
